// File: rtl/timepulse_multi_pkg.sv
// Shared definitions for the multi-channel pulse timebase: channel mode encoding and the
// default period.
package timepulse_multi_pkg;

    typedef enum logic {
        ModePeriodic = 1'b0,
        ModeOneshot  = 1'b1
    } mode_e;

    localparam int unsigned DefaultPeriod = 128;

endpackage

// File: rtl/timepulse_chan.sv
// One pulse channel: shadow/active period and mode, down-counter, tick and sticky done flag.
module timepulse_chan
    import timepulse_multi_pkg::*;
#(
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned DEFAULT_PERIOD = DefaultPeriod
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                en_i,
    input  logic                sync_i,
    input  logic                we_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                oneshot_i,
    output logic                tp_o,
    output logic                done_o
);

    localparam logic [PERIOD_W-1:0] RstPeriod = PERIOD_W'(DEFAULT_PERIOD);

    logic [PERIOD_W-1:0] sh_period_q, sh_period_d;
    mode_e               sh_mode_q, sh_mode_d;
    logic [PERIOD_W-1:0] act_period_q, act_period_d;
    mode_e               act_mode_q, act_mode_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                tp_q, tp_d;
    logic [PERIOD_W-1:0] sh_reload;

    // A zero period reloads 0 rather than wrapping to all-ones; the channel then stalls.
    assign sh_reload = (sh_period_q == '0) ? '0 : sh_period_q - PERIOD_W'(1);

    always_comb begin
        sh_period_d  = sh_period_q;
        sh_mode_d    = sh_mode_q;
        act_period_d = act_period_q;
        act_mode_d   = act_mode_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        tp_d         = 1'b0;

        if (we_i) begin
            sh_period_d = period_i;
            sh_mode_d   = oneshot_i ? ModeOneshot : ModePeriodic;
        end

        // Reloads read the pre-edge shadow, so a coincident write lands at the next reload.
        if (!en_i || sync_i) begin
            act_period_d = sh_period_q;
            act_mode_d   = sh_mode_q;
            cnt_d        = sh_reload;
            done_d       = 1'b0;
        end else if (done_q || act_period_q == '0) begin
            tp_d = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PERIOD_W'(1);
        end else begin
            tp_d = 1'b1;
            if (act_mode_q == ModeOneshot) begin
                done_d = 1'b1;
            end else begin
                act_period_d = sh_period_q;
                act_mode_d   = sh_mode_q;
                cnt_d        = sh_reload;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_period_q  <= RstPeriod;
            sh_mode_q    <= ModePeriodic;
            act_period_q <= RstPeriod;
            act_mode_q   <= ModePeriodic;
            cnt_q        <= RstPeriod - PERIOD_W'(1);
            done_q       <= 1'b0;
            tp_q         <= 1'b0;
        end else begin
            sh_period_q  <= sh_period_d;
            sh_mode_q    <= sh_mode_d;
            act_period_q <= act_period_d;
            act_mode_q   <= act_mode_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            tp_q         <= tp_d;
        end
    end

    assign tp_o   = tp_q;
    assign done_o = done_q;

`ifdef FORMAL
    a_tick_reload: assert property (@(posedge clk_i) disable iff (!rstn_i)
        tp_q |-> $past(cnt_q == '0));
    a_cnt_dec: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (en_i && !sync_i && !done_q && act_period_q != '0 && cnt_q != '0)
        |=> cnt_q == $past(cnt_q) - PERIOD_W'(1));
    a_no_double: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (tp_q && act_period_q >= PERIOD_W'(2)) |=> !tp_q);
`endif

endmodule

// File: rtl/timepulse_multi.sv
// CHANNELS independent programmable tick generators sharing one config port and a global sync.
module timepulse_multi
    import timepulse_multi_pkg::*;
#(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned DEFAULT_PERIOD = DefaultPeriod,
    localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [CHANNELS-1:0] en_i,
    input  logic                sync_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic                cfg_oneshot_i,
    output logic [CHANNELS-1:0] tp_o,
    output logic [CHANNELS-1:0] done_o
);

    logic [CHANNELS-1:0] ch_we;

    // Selects at or above CHANNELS match no channel, so such writes are dropped.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_we[i] = cfg_we_i && (int'(cfg_ch_i) == i);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        timepulse_chan #(
            .PERIOD_W       (PERIOD_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .en_i      (en_i[g]),
            .sync_i    (sync_i),
            .we_i      (ch_we[g]),
            .period_i  (cfg_period_i),
            .oneshot_i (cfg_oneshot_i),
            .tp_o      (tp_o[g]),
            .done_o    (done_o[g])
        );
    end

`ifdef FORMAL
    c_all_done: cover property (@(posedge clk_i) &done_o);
`endif

endmodule
